// File: rtl/vc_tx_arbiter.sv
// vc_tx_arbiter: ingress words are steered by their VC field into per-VC FIFOs and drained to one
// egress port by a round-robin arbiter. Define VC_ARB_STRICT_PRIO_EN for fixed lowest-index priority.

module vc_tx_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the count gates every read that matters.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = cnt_q;
endmodule

module vc_tx_arbiter #(
  parameter int DATA_WIDTH   = 6,
  parameter int VC_IDX_WIDTH = 2,
  parameter int ADDR_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [ADDR_WIDTH:0]       umbral_af,
  input  logic [ADDR_WIDTH:0]       umbral_ae,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      out_valid,
  output logic [VC_IDX_WIDTH-1:0]   out_vc,
  output logic [2**VC_IDX_WIDTH-1:0] empty_vec,
  output logic [2**VC_IDX_WIDTH-1:0] almost_full_vec,
  output logic [2**VC_IDX_WIDTH-1:0] almost_empty_vec,
  output logic                      error_out,
  output logic                      active_out,
  output logic                      idle_out,
  output logic [2:0]                state
);
  localparam int NUM_VC = 2**VC_IDX_WIDTH;
  localparam int DEPTH  = 2**ADDR_WIDTH;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_RST   = (ADDR_WIDTH+1)'(DEPTH-1);
  localparam logic [ADDR_WIDTH:0] AE_RST   = (ADDR_WIDTH+1)'(1);

  logic [2:0]                  state_q, state_d;
  logic [ADDR_WIDTH:0]         af_q, af_d, ae_q, ae_d;
  logic [VC_IDX_WIDTH-1:0]     rr_q, rr_d;
  logic [DATA_WIDTH-1:0]       data_out_q, data_out_d;
  logic                        out_valid_q, out_valid_d;
  logic [VC_IDX_WIDTH-1:0]     out_vc_q, out_vc_d;
  logic                        error_q, error_d;

  logic [NUM_VC-1:0][ADDR_WIDTH:0]   cnt;
  logic [NUM_VC-1:0][DATA_WIDTH-1:0] head;
  logic [NUM_VC-1:0]                 wr_en, rd_en;

  logic                    run, flush, push_full, push_ok, err_evt, gnt_any;
  logic [VC_IDX_WIDTH-1:0] push_vc, gnt_idx, cand;

  assign run       = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign flush     = (state_q == ST_INIT);
  assign push_vc   = data_in[DATA_WIDTH-1 -: VC_IDX_WIDTH];
  // Full is judged on the pre-grant count, so a same-cycle grant never rescues a push.
  assign push_full = (cnt[push_vc] == CNT_FULL);
  assign push_ok   = run && push && !push_full;
  assign err_evt   = run && push && push_full;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_en[v] = push_ok && (push_vc == VC_IDX_WIDTH'(v));
    assign rd_en[v] = gnt_any && (gnt_idx == VC_IDX_WIDTH'(v));

    vc_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .wr_en   (wr_en[v]),
      .wr_data (data_in),
      .rd_en   (rd_en[v]),
      .rd_data (head[v]),
      .count   (cnt[v])
    );

    assign empty_vec[v]        = (cnt[v] == '0);
    assign almost_full_vec[v]  = (cnt[v] >= af_q);
    assign almost_empty_vec[v] = (cnt[v] <= ae_q);
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_VC; i++) begin
`ifdef VC_ARB_STRICT_PRIO_EN
      cand = VC_IDX_WIDTH'(i);
`else
      cand = rr_q + VC_IDX_WIDTH'(i + 1);
`endif
      if (run && pop && !gnt_any && !empty_vec[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  if (init) state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)         state_d = ST_INIT;
        else if (err_evt) state_d = ST_ERROR;
        else if (push_ok) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)         state_d = ST_INIT;
        else if (err_evt) state_d = ST_ERROR;
        else if ((&empty_vec) && !push && !gnt_any) state_d = ST_IDLE;
      end
      ST_ERROR:  if (init) state_d = ST_INIT;
      default:   state_d = ST_RESET;
    endcase
  end

  always_comb begin
    error_d     = (state_d == ST_ERROR);
    af_d        = (flush && init) ? umbral_af : af_q;
    ae_d        = (flush && init) ? umbral_ae : ae_q;
    out_valid_d = gnt_any;
    data_out_d  = gnt_any ? head[gnt_idx] : data_out_q;
    out_vc_d    = gnt_any ? gnt_idx : out_vc_q;
`ifdef VC_ARB_STRICT_PRIO_EN
    rr_d        = rr_q;
`else
    rr_d        = gnt_any ? gnt_idx : rr_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RESET;
      af_q        <= AF_RST;
      ae_q        <= AE_RST;
      rr_q        <= VC_IDX_WIDTH'(NUM_VC - 1);
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      rr_q        <= rr_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_vc_q    <= out_vc_d;
      error_q     <= error_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign out_vc     = out_vc_q;
  assign error_out  = error_q;
  assign active_out = (state_q == ST_ACTIVE);
  assign idle_out   = (state_q == ST_IDLE);
  assign state      = state_q;
endmodule

// File: tb/tb_vc_tx_arbiter.sv
// Scenario bench for vc_tx_arbiter: per-VC expected-word queues filled at push time, drained on out_valid.
module tb_vc_tx_arbiter;
  localparam int DW = 6, VW = 2, AW = 2, NV = 4;

  logic clk = 1'b0;
  logic reset, init, push, pop;
  logic [AW:0] umbral_af, umbral_ae;
  logic [DW-1:0] data_in, data_out;
  logic out_valid;
  logic [VW-1:0] out_vc;
  logic [NV-1:0] empty_vec, almost_full_vec, almost_empty_vec;
  logic error_out, active_out, idle_out;
  logic [2:0] state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] sbq [NV][$];

  always #5 clk = ~clk;

  vc_tx_arbiter #(.DATA_WIDTH(DW), .VC_IDX_WIDTH(VW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .init(init), .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .out_valid(out_valid),
    .out_vc(out_vc), .empty_vec(empty_vec), .almost_full_vec(almost_full_vec),
    .almost_empty_vec(almost_empty_vec), .error_out(error_out), .active_out(active_out),
    .idle_out(idle_out), .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    push = 1'b1;
    data_in = d;
    sbq[d[DW-1 -: VW]].push_back(d);
    tick();
    push = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_af = '0; umbral_ae = '0;
    tick(); tick();
    tests_run++;
    if (state !== 3'd0 || empty_vec !== 4'hF || out_valid !== 1'b0 || data_out !== 6'h0 ||
        out_vc !== 2'd0 || error_out !== 1'b0 || idle_out !== 1'b0 || active_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got st=%0d empty=%h v=%b d=%h vc=%0d err=%b idle=%b act=%b",
               state, empty_vec, out_valid, data_out, out_vc, error_out, idle_out, active_out);
    end
    tests_run++;
    if (almost_full_vec !== 4'h0 || almost_empty_vec !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_flags got af=%h ae=%h want af=0 ae=f", almost_full_vec, almost_empty_vec);
    end
    reset = 1'b1;
  endtask

  task automatic test_init();
    init = 1'b1; umbral_af = 3'd3; umbral_ae = 3'd1;
    tick();
    tests_run++;
    if (state !== 3'd1) begin tests_failed++; $display("FAIL init_enter got %0d want 1", state); end
    tick();
    init = 1'b0;
    tick();
    tests_run++;
    if (state !== 3'd2 || idle_out !== 1'b1 || empty_vec !== 4'hF) begin
      tests_failed++;
      $display("FAIL init_to_idle got st=%0d idle=%b empty=%h want 2 1 f", state, idle_out, empty_vec);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d;
    do_push(6'h31);
    tests_run++;
    if (state !== 3'd3 || active_out !== 1'b1 || empty_vec !== 4'h7) begin
      tests_failed++;
      $display("FAIL single_active got st=%0d act=%b empty=%h want 3 1 7", state, active_out, empty_vec);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    exp_d = (sbq[3].size() > 0) ? sbq[3].pop_front() : 6'h0;
    tests_run++;
    if (out_valid !== 1'b1 || data_out !== exp_d || out_vc !== 2'd3) begin
      tests_failed++;
      $display("FAIL single_out got v=%b d=%h vc=%0d want 1 %h 3", out_valid, data_out, out_vc, exp_d);
    end
    tick();
    tests_run++;
    if (state !== 3'd2 || out_valid !== 1'b0 || data_out !== exp_d) begin
      tests_failed++;
      $display("FAIL single_idle_hold got st=%0d v=%b d=%h want 2 0 %h", state, out_valid, data_out, exp_d);
    end
  endtask

  task automatic test_full_error();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; data_in = 6'h10 + 6'(i);
      tick();
      if (i == 1 || i == 2) begin
        tests_run++;
        if (almost_full_vec[1] !== (i == 2)) begin
          tests_failed++;
          $display("FAIL full_af_push%0d got %b want %b", i + 1, almost_full_vec[1], (i == 2));
        end
      end
    end
    data_in = 6'h14;
    tick();
    tests_run++;
    if (error_out !== 1'b1 || state !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_error got err=%b st=%0d want 1 4", error_out, state);
    end
    data_in = 6'h25; pop = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    tests_run++;
    if (state !== 3'd4 || empty_vec !== 4'hD || out_valid !== 1'b0 || error_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL error_ignore got st=%0d empty=%h v=%b err=%b want 4 d 0 1",
               state, empty_vec, out_valid, error_out);
    end
    init = 1'b1;
    tick();
    tests_run++;
    if (state !== 3'd1 || error_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL error_clear got st=%0d err=%b want 1 0", state, error_out);
    end
    tick();
    init = 1'b0;
    tests_run++;
    if (empty_vec !== 4'hF) begin tests_failed++; $display("FAIL flush got %h want f", empty_vec); end
    tick();
    tests_run++;
    if (state !== 3'd2) begin tests_failed++; $display("FAIL reinit_idle got %0d want 2", state); end
  endtask

  task automatic drain_check(input string name, input logic [VW-1:0] exp_vc);
    logic [DW-1:0] exp_d;
    exp_d = (sbq[exp_vc].size() > 0) ? sbq[exp_vc].pop_front() : 6'h0;
    tests_run++;
    if (out_valid !== 1'b1 || out_vc !== exp_vc || data_out !== exp_d) begin
      tests_failed++;
      $display("FAIL %s got v=%b vc=%0d d=%h want 1 %0d %h", name, out_valid, out_vc, data_out, exp_vc, exp_d);
    end
  endtask

  task automatic test_round_robin();
    do_push(6'h05); do_push(6'h1A); do_push(6'h2C); do_push(6'h3F);
    pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      drain_check($sformatf("rr_out%0d", k), VW'(k));
    end
    tick();
    pop = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || error_out !== 1'b0 || data_out !== 6'h3F || state !== 3'd2) begin
      tests_failed++;
      $display("FAIL rr_pop_empty got v=%b err=%b d=%h st=%0d want 0 0 3f 2",
               out_valid, error_out, data_out, state);
    end
  endtask

  task automatic test_refill();
    logic [VW-1:0] exp_seq [7];
`ifdef VC_ARB_STRICT_PRIO_EN
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
`else
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    do_push(6'h01); do_push(6'h11); do_push(6'h22);
    pop = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        push = 1'b1; data_in = 6'h02 + 6'(k);
        sbq[0].push_back(data_in);
      end else begin
        push = 1'b0;
      end
      tick();
      drain_check($sformatf("refill_out%0d", k), exp_seq[k]);
    end
    push = 1'b0; pop = 1'b0;
    tick();
    tests_run++;
    if (empty_vec !== 4'hF || state !== 3'd2) begin
      tests_failed++;
      $display("FAIL refill_end got empty=%h st=%0d want f 2", empty_vec, state);
    end
  endtask

  task automatic test_simul_push_pop();
    do_push(6'h21); do_push(6'h22);
    push = 1'b1; data_in = 6'h23; sbq[2].push_back(6'h23);
    pop = 1'b1;
    tick();
    push = 1'b0;
    drain_check("simul_out", 2'd2);
    tests_run++;
    if (almost_full_vec[2] !== 1'b0 || almost_empty_vec[2] !== 1'b0 || empty_vec[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_count got af=%b ae=%b e=%b want count 2 (0 0 0)",
               almost_full_vec[2], almost_empty_vec[2], empty_vec[2]);
    end
    tick(); drain_check("simul_order0", 2'd2);
    tick(); drain_check("simul_order1", 2'd2);
    pop = 1'b0;
  endtask

  task automatic test_async_reset();
    do_push(6'h3A);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    drain_check("areset_pre", 2'd3);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || data_out !== 6'h0 || out_vc !== 2'd0 || state !== 3'd0 ||
        empty_vec !== 4'hF || error_out !== 1'b0 || active_out !== 1'b0 || idle_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset got v=%b d=%h vc=%0d st=%0d empty=%h err=%b act=%b idle=%b",
               out_valid, data_out, out_vc, state, empty_vec, error_out, active_out, idle_out);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_init();
    test_single();
    test_full_error();
    test_round_robin();
    test_refill();
    test_simul_push_pop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/vc_tx_arbiter.md
Name: vc_tx_arbiter

Overview:
- Parametrised successor to the two-VC transmission-layer front end.
- Accepts a single ingress stream and routes each word by its VC field into one of NUM_VC internal FIFOs.
- Drains the FIFOs to a single egress port through a round-robin arbiter.
- Carries an integrated RESET/INIT/IDLE/ACTIVE/ERROR control FSM with runtime-programmable almost-full and almost-empty thresholds latched during INIT.

Parameters:
- DATA_WIDTH, 6, ingress/egress word width; the VC field is the top VC_IDX_WIDTH bits.
- VC_IDX_WIDTH, 2, width of the VC field; NUM_VC = 2**VC_IDX_WIDTH.
- ADDR_WIDTH, 2, per-VC FIFO address width; DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  enter/hold INIT and latch thresholds.
- umbral_af  in  ADDR_WIDTH+1  almost-full threshold (occupancy count).
- umbral_ae  in  ADDR_WIDTH+1  almost-empty threshold.
- push  in  1  ingress write strobe.
- data_in  in  DATA_WIDTH  ingress word.
- pop  in  1  egress request (downstream ready).
- data_out  out  DATA_WIDTH  registered egress word.
- out_valid  out  1  data_out valid this cycle.
- out_vc  out  VC_IDX_WIDTH  VC that supplied data_out.
- empty_vec  out  NUM_VC  per-VC empty.
- almost_full_vec  out  NUM_VC  per-VC count >= latched umbral_af.
- almost_empty_vec  out  NUM_VC  per-VC count <= latched umbral_ae.
- error_out  out  1  registered, sticky error flag.
- active_out  out  1  FSM is in ACTIVE.
- idle_out  out  1  FSM is in IDLE.
- state  out  3  encoded FSM state.

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFO pointers and counts go to 0; empty_vec is all ones.
  - data_out=0, out_valid=0, out_vc=0, error_out=0, active_out=0, idle_out=0.
  - Latched thresholds: af=DEPTH-1, ae=1. Round-robin pointer = NUM_VC-1.
  - state=RESET (3'd0).
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. All transitions are registered.
  - RESET: init=1 -> INIT.
  - INIT: umbral_af and umbral_ae are latched every cycle while init=1. FIFOs are flushed on entry. init=0 -> IDLE.
  - IDLE: idle_out=1. An accepted push -> ACTIVE. init=1 -> INIT.
  - ACTIVE: active_out=1. All FIFOs empty, no push and no grant this cycle -> IDLE. init=1 -> INIT.
  - Any error event in IDLE or ACTIVE -> ERROR.
  - ERROR: error_out=1, sticky. Only init=1 (-> INIT, error cleared, FIFOs flushed) or reset leaves ERROR.
- Ingress:
  - push is honoured only in IDLE and ACTIVE. In RESET, INIT and ERROR it is silently dropped with no error.
  - Target VC = data_in[DATA_WIDTH-1 -: VC_IDX_WIDTH].
  - Push to a VC whose count==DEPTH: the word is dropped and an error event is raised. This holds even if the same VC is granted in the same cycle.
- Egress:
  - Grants are issued only in IDLE and ACTIVE.
  - When pop=1 and at least one VC is non-empty, the arbiter grants the first non-empty VC after the RR pointer, searching in wrap-around order.
  - The head word is registered to data_out with out_valid=1 and out_vc set, on the next edge (1-cycle latency). The RR pointer is updated to the granted VC.
  - pop=1 with all FIFOs empty: out_valid=0 next cycle, no error.
  - pop=0: out_valid=0 next cycle; data_out holds its last value.
- Simultaneous push and grant on the same non-full VC: both take effect and the count is unchanged.
- Flag vectors are combinational from the counts and the latched thresholds.
- Counts are ADDR_WIDTH+1 bits; pointers wrap modulo DEPTH.
- Reset asserted mid-transfer aborts everything immediately; in-flight data is lost.

Optional Feature:
- Macro: VC_ARB_STRICT_PRIO_EN.
- Defined: the arbiter is strict-priority; the lowest-index non-empty VC always wins, and the RR pointer is unused and stays at its reset value.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, init=1 with umbral_af=3 and umbral_ae=1 for 2 cycles, then init=0 -> state sequence 0,1,2; idle_out=1; empty_vec=4'hF.
- In IDLE, push 6'h31 (VC3), then pop next cycle -> ACTIVE one cycle after the push; data_out=6'h31, out_vc=3, out_valid=1 one cycle after pop; returns to IDLE.
- Push 4 words to VC1 -> almost_full_vec[1]=1 after the third; a 5th push drops the word, error_out=1 next cycle, state=4; pushes are then ignored; init=1 -> INIT with error_out=0.
- Load one word each into VC0..VC3, then hold pop=1 -> out_vc sequence 0,1,2,3 under default RR. With VC_ARB_STRICT_PRIO_EN and VC0 refilled each cycle -> out_vc stays 0.
- Simultaneous push and pop on VC2 at count 2 -> count stays 2; data order preserved (FIFO).
- Pull reset low while out_valid=1 -> all outputs are at reset values asynchronously, before the next clk edge.
